// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: row-scan controller for the RGB LED matrix.
// Snapshots the LED state vectors once per frame, then drives the matrix one
// row at a time with a blanking gap before each row and a programmable dwell.
module led_scan_ctrl #(
  parameter int NUM_ROWS     = 10,
  parameter int NUM_COLS     = 12,
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [DWELL_W-1:0]           dwell_i,
  input  logic [NUM_ROWS*NUM_COLS-1:0] led_r_i,
  input  logic [NUM_ROWS*NUM_COLS-1:0] led_g_i,
  input  logic [NUM_ROWS*NUM_COLS-1:0] led_b_i,
  output logic [NUM_ROWS-1:0]          row_o,
  output logic [NUM_COLS-1:0]          col_r_o,
  output logic [NUM_COLS-1:0]          col_g_o,
  output logic [NUM_COLS-1:0]          col_b_o,
  output logic                         frame_o,
  output logic                         busy_o
);

  localparam int LEDS  = NUM_ROWS * NUM_COLS;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] BLANK = 2'd2;
  localparam logic [1:0] DRIVE = 2'd3;

  localparam logic [DWELL_W-1:0] BLANK_LAST = DWELL_W'(BLANK_CYCLES - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(NUM_ROWS - 1);

  logic [1:0]         state;
  logic [ROW_W-1:0]   row_idx;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_r;
  logic [LEDS-1:0]    shadow_r;
  logic [LEDS-1:0]    shadow_g;
  logic [LEDS-1:0]    shadow_b;
  logic               blank_done;
  logic               drive_done;
  int                 row_base;

  // The same counter times both the blanking gap and the row dwell; dwell_r is
  // never zero, so dwell_r-1 never underflows and the counter never wraps.
  assign blank_done = (cnt == BLANK_LAST);
  assign drive_done = (cnt == dwell_r - DWELL_W'(1));
  assign row_base   = int'(row_idx) * NUM_COLS;

  // Scan sequencer: snapshot once per frame, then blank/drive each row in turn.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      row_idx  <= '0;
      cnt      <= '0;
      dwell_r  <= DWELL_W'(1);
      shadow_r <= '0;
      shadow_g <= '0;
      shadow_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en_i) state <= LOAD;
        end
        LOAD: begin
          shadow_r <= led_r_i;
          shadow_g <= led_g_i;
          shadow_b <= led_b_i;
          row_idx  <= '0;
          cnt      <= '0;
          state    <= BLANK;
        end
        BLANK: begin
          if (blank_done) begin
            cnt     <= '0;
            dwell_r <= (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
            state   <= DRIVE;
          end else begin
            cnt <= cnt + DWELL_W'(1);
          end
        end
        DRIVE: begin
          if (drive_done) begin
            cnt <= '0;
            if (row_idx == LAST_ROW) begin
              state <= en_i ? LOAD : IDLE;
            end else begin
              row_idx <= row_idx + ROW_W'(1);
              state   <= BLANK;
            end
          end else begin
            cnt <= cnt + DWELL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pin outputs decode purely from registered state; nothing is lit outside DRIVE.
  always_comb begin
    row_o   = '0;
    col_r_o = '0;
    col_g_o = '0;
    col_b_o = '0;
    if (state == DRIVE) begin
      row_o   = NUM_ROWS'(1) << row_idx;
      col_r_o = shadow_r[row_base +: NUM_COLS];
      col_g_o = shadow_g[row_base +: NUM_COLS];
      col_b_o = shadow_b[row_base +: NUM_COLS];
    end
  end

  assign frame_o = (state == DRIVE) && (row_idx == LAST_ROW) && drive_done;
  assign busy_o  = (state != IDLE);

endmodule

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Row-scan controller for the 12×10 RGB LED matrix. Snapshots the 120-bit red/green/blue state vectors produced by the memory-mapped LED register block at the start of every frame, then drives the physical matrix one row at a time: one-hot row select, 12 column lines per colour, a blanking gap between rows, and a programmable per-row dwell. It sits between the LED register block and the board pins, and sequences readout of that block's state so the display never tears mid-frame.

## Interface
Parameters:
- `NUM_ROWS`, 10, matrix rows.
- `NUM_COLS`, 12, matrix columns. LED index = row*NUM_COLS + col.
- `DWELL_W`, 16, width of dwell count.
- `BLANK_CYCLES`, 4, all-off cycles before each row is driven; must be ≥1.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `en_i`  in  1  scan enable.
- `dwell_i`  in  DWELL_W  row on-time in cycles; 0 is treated as 1.
- `led_r_i`, `led_g_i`, `led_b_i`  in  NUM_ROWS*NUM_COLS each  LED state vectors.
- `row_o`  out  NUM_ROWS  one-hot active-high row select; all-zero when not driving.
- `col_r_o`, `col_g_o`, `col_b_o`  out  NUM_COLS each  column data for the selected row.
- `frame_o`  out  1  one-cycle pulse on the last DRIVE cycle of row NUM_ROWS-1.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, BLANK, DRIVE. All outputs decode from registered state only. There is no combinational path from any input to any output.
- **IDLE**
  - row_o, col_*_o and frame_o are 0.
  - en_i=1 → LOAD.
- **LOAD** (exactly 1 cycle)
  - Copy led_r_i/g_i/b_i into shadow registers.
  - row_idx ← 0.
  - → BLANK.
- **BLANK**
  - row_o=0 and cols=0 for BLANK_CYCLES cycles.
  - On the last BLANK cycle, sample dwell_r ← max(dwell_i, 1).
  - → DRIVE.
- **DRIVE**
  - row_o = 1<<row_idx.
  - col_X_o[c] = shadow_X[row_idx*NUM_COLS + c].
  - Held for dwell_r cycles.
  - On the last DRIVE cycle, if row_idx < NUM_ROWS-1: row_idx+1 → BLANK.
  - On the last DRIVE cycle, if row_idx = NUM_ROWS-1: frame_o=1. Then → LOAD if en_i=1, else → IDLE.
- en_i deasserted mid-frame: the current frame completes through row NUM_ROWS-1, then IDLE. No partial frames.
- led_*_i changes during a frame: ignored until the next LOAD.
- dwell_i changes: take effect at the next row boundary (sampled per row in BLANK).
- Counters:
  - Cycle counter is DWELL_W bits and compares against dwell_r-1. It never wraps, because dwell_r ≥ 1.
  - row_idx is ceil(log2(NUM_ROWS)) bits and never exceeds NUM_ROWS-1.

## Timing
- Reset (rst_i=1 at an edge), on the following cycle:
  - state=IDLE, row_idx=0, counter=0, shadow registers=0.
  - row_o=0, col_*_o=0, frame_o=0, busy_o=0.
- Reset takes priority over everything, including mid-DRIVE. Outputs are 0 the cycle after.
- Counting from the edge at which en_i=1 is sampled in IDLE (cycle 0):
  - LOAD occupies cycle 1.
  - BLANK occupies cycles 2..BLANK_CYCLES+1.
  - Row 0 is driven from cycle BLANK_CYCLES+2.
- Frame length with en_i held high = 1 + NUM_ROWS*(BLANK_CYCLES+dwell) cycles. LOAD of the next frame immediately follows the frame_o cycle.
- Row select is never active on two rows in the same cycle, and row_o is never nonzero in two consecutive rows without at least BLANK_CYCLES of zero between them.
- frame_o is high for exactly 1 cycle per frame, coincident with the last DRIVE cycle of row NUM_ROWS-1.

## Test plan
- **Reset mid-DRIVE.** Assert rst_i during row 3. Required next cycle: all outputs 0, busy_o=0. With en_i=1 still asserted, the controller restarts at LOAD one cycle after reset is released.
- **Single-LED mapping.** led_r_i = 1<<(2*12+5), dwell_i=3, BLANK_CYCLES=4. Required:
  - row 2 shows col_r_o=12'h020, row_o=10'h004 for exactly 3 cycles;
  - every other row shows col_r_o=0;
  - col_g_o = col_b_o = 0 throughout.
- **Frame cadence.** en_i held high, dwell_i=3. Required:
  - frame_o pulses every 71 cycles;
  - first row_o=10'h001 appears at cycle 6 after en_i is sampled.
- **Snapshot isolation.** Toggle all led_*_i bits every cycle during a frame. Required: displayed columns equal the values present in the LOAD cycle for the whole frame.
- **Dwell edge cases.**
  - dwell_i=0 behaves as dwell 1, giving a 51-cycle frame.
  - Changing dwell_i from 3 to 5 during row 4's DRIVE gives rows 5..9 a dwell of 5 and leaves row 4 at 3.
- **Disable mid-frame.** Drop en_i during row 6. Required: rows 6–9 complete, frame_o pulses, then IDLE with busy_o=0 and all outputs 0.
